dds_phase_gen: RTL and testbench

Programmable NCO phase source for the sincos CORDIC stage. It replaces the fixed "+256 per clock" phase counter with a 32-bit phase accumulator. The accumulator takes a runtime frequency tuning word (FTW), a phase offset, and optional linear frequency sweep (chirp). Output is an AXI-Stream-style phase beat (valid/ready) that drives the CORDIC s_axis_phase port directly.

---
 rtl/dds_phase_gen.sv | 168 ++++++++++++++++
 tb/tb_dds_phase_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: programmable NCO phase source for the sincos CORDIC.
// A 32-bit phase accumulator advanced by a runtime tuning word, with a
// phase offset at the output and optional linear FTW sweep (chirp).
// The phase leaves as a valid/ready stream beat.
module dds_phase_gen #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [ACC_W-1:0]   cfg_ftw,
    input  logic [ACC_W-1:0]   cfg_ftw_end,
    input  logic [ACC_W-1:0]   cfg_ftw_step,
    input  logic [PHASE_W-1:0] cfg_poff,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic [PHASE_W-1:0] m_axis_phase_tdata,
    output logic               sweep_done,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [1:0] MODE_ONCE   = 2'b01;
    localparam logic [1:0] MODE_REPEAT = 2'b10;

    state_t r_state;
    state_t w_state_next;

    // configuration registers
    logic [1:0]         r_mode;
    logic [ACC_W-1:0]   r_ftw_start;
    logic [ACC_W-1:0]   r_ftw_end;
    logic [ACC_W-1:0]   r_step;
    logic [PHASE_W-1:0] r_poff;

    // datapath registers
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_ftw_cur;
    logic               r_at_end;   // r_ftw_cur has been clamped to the sweep end
    logic               r_last;     // the beat on the output is the final sweep-once beat
    logic               r_tvalid;
    logic [PHASE_W-1:0] r_tdata;
    logic               r_sweep_done;

    logic               w_accept;
    logic               w_sweep;
    logic               w_finish;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W:0]     w_ftw_sum;
    logic               w_sum_ge_end;

    // Output phase: top bits of the accumulator plus offset, wrapping mod 2^PHASE_W.
    function automatic logic [PHASE_W-1:0] f_phase(input logic [PHASE_W-1:0] top,
                                                   input logic [PHASE_W-1:0] poff);
        return top + poff;
    endfunction

    assign cfg_ready           = 1'b1;
    assign m_axis_phase_tvalid = r_tvalid;
    assign m_axis_phase_tdata  = r_tdata;
    assign sweep_done          = r_sweep_done;

    assign w_accept     = r_tvalid & m_axis_phase_tready;
    assign w_sweep      = (r_mode == MODE_ONCE) || (r_mode == MODE_REPEAT);
    assign w_acc_next   = r_acc + r_ftw_cur;
    // One extra bit so a sweep that would overflow still counts as reaching the end.
    assign w_ftw_sum    = {1'b0, r_ftw_cur} + {1'b0, r_step};
    assign w_sum_ge_end = (w_ftw_sum >= {1'b0, r_ftw_end});
    // Leave RUN after the final sweep-once beat is taken, or when enable drops
    // and no beat is left waiting on a stalled downstream.
    assign w_finish     = (r_state == RUN) &&
                          ((w_accept && r_last) ||
                           (!enable && !(r_tvalid && !m_axis_phase_tready)));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)   w_state_next = RUN;
            RUN:     if (w_finish) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (r_state == RUN);
    end

    // Accumulator, tuning word, sweep tracking, beat register and config capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode       <= '0;
            r_ftw_start  <= '0;
            r_ftw_end    <= '0;
            r_step       <= '0;
            r_poff       <= '0;
            r_acc        <= '0;
            r_ftw_cur    <= '0;
            r_at_end     <= 1'b0;
            r_last       <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            if (r_state == IDLE) begin
                if (enable) begin
                    r_acc    <= '0;
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_poff;
                    r_at_end <= 1'b0;
                    r_last   <= 1'b0;
                end
            end else if (w_finish) begin
                r_tvalid     <= 1'b0;
                r_sweep_done <= w_accept & r_last;
                r_at_end     <= 1'b0;
                r_last       <= 1'b0;
            end else if (w_accept) begin
                r_acc   <= w_acc_next;
                r_tdata <= f_phase(w_acc_next[ACC_W-1 -: PHASE_W], r_poff);
                if (w_sweep) begin
                    if (r_at_end) begin
                        // This update ran at the end FTW.
                        if (r_mode == MODE_ONCE) begin
                            r_last <= 1'b1;
                        end else begin
                            r_ftw_cur <= r_ftw_start;
                            r_at_end  <= 1'b0;
                        end
                    end else if (w_sum_ge_end) begin
                        r_ftw_cur <= r_ftw_end;
                        r_at_end  <= 1'b1;
                    end else begin
                        r_ftw_cur <= w_ftw_sum[ACC_W-1:0];
                    end
                end
            end
            // Config wins over the sweep update; the beat above already used the old values.
            if (cfg_valid) begin
                r_mode      <= cfg_mode;
                r_ftw_start <= cfg_ftw;
                r_ftw_cur   <= cfg_ftw;
                r_ftw_end   <= cfg_ftw_end;
                r_step      <= cfg_ftw_step;
                r_poff      <= cfg_poff;
                r_at_end    <= 1'b0;
                r_last      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed testbench for dds_phase_gen.
module tb_dds_phase_gen;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [1:0]         cfg_mode = 2'b00;
    logic [ACC_W-1:0]   cfg_ftw = '0;
    logic [ACC_W-1:0]   cfg_ftw_end = '0;
    logic [ACC_W-1:0]   cfg_ftw_step = '0;
    logic [PHASE_W-1:0] cfg_poff = '0;
    logic               tvalid;
    logic               tready = 1'b1;
    logic [PHASE_W-1:0] tdata;
    logic               sweep_done;
    logic               busy;

    int n_chk = 0;
    int n_err = 0;

    dds_phase_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_mode            (cfg_mode),
        .cfg_ftw             (cfg_ftw),
        .cfg_ftw_end         (cfg_ftw_end),
        .cfg_ftw_step        (cfg_ftw_step),
        .cfg_poff            (cfg_poff),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .m_axis_phase_tdata  (tdata),
        .sweep_done          (sweep_done),
        .busy                (busy)
    );

    always #4 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_cfg(input logic [1:0] mode, input logic [31:0] ftw,
                          input logic [31:0] fend, input logic [31:0] step,
                          input logic [15:0] poff);
        cfg_mode = mode; cfg_ftw = ftw; cfg_ftw_end = fend;
        cfg_ftw_step = step; cfg_poff = poff; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
        n_chk++; if (tdata !== 16'h0000) begin n_err++; $display("FAIL reset_tdata got=%h exp=0000", tdata); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_chk++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", sweep_done); end
        n_chk++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_continuous();
        logic [15:0] exp;
        do_cfg(2'b00, 32'h0100_0000, 32'h0, 32'h0, 16'h0000);
        enable = 1'b1;
        tick();
        n_chk++; if (tvalid !== 1'b1 || tdata !== 16'h0000) begin
            n_err++; $display("FAIL cont_first got=%b/%h exp=1/0000", tvalid, tdata); end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL cont_busy got=%b exp=1", busy); end
        for (int k = 1; k <= 256; k++) begin
            tick();
            exp = 16'(k * 32'h100);
            n_chk++; if (tdata !== exp || tvalid !== 1'b1) begin
                n_err++; $display("FAIL cont_beat%0d got=%b/%h exp=1/%h", k, tvalid, tdata, exp); end
        end
        enable = 1'b0;
        tick();
        n_chk++; if (tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL cont_stop got=%b/%b exp=0/0", tvalid, busy); end
    endtask

    task automatic test_poff();
        logic [15:0] exp;
        do_cfg(2'b00, 32'h0100_0000, 32'h0, 32'h0, 16'h4000);
        enable = 1'b1;
        tick();
        n_chk++; if (tdata !== 16'h4000) begin n_err++; $display("FAIL poff_first got=%h exp=4000", tdata); end
        for (int k = 1; k <= 200; k++) begin
            tick();
            exp = 16'(32'h4000 + k * 32'h100);
            n_chk++; if (tdata !== exp) begin
                n_err++; $display("FAIL poff_beat%0d got=%h exp=%h", k, tdata, exp); end
            if (k == 191) begin
                n_chk++; if (tdata !== 16'hFF00) begin n_err++; $display("FAIL poff_pre_wrap got=%h exp=ff00", tdata); end
            end
            if (k == 192) begin
                n_chk++; if (tdata !== 16'h0000) begin n_err++; $display("FAIL poff_wrap got=%h exp=0000", tdata); end
            end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        do_cfg(2'b00, 32'h0100_0000, 32'h0, 32'h0, 16'h0000);
        enable = 1'b1;
        tick(); tick(); tick(); tick();
        n_chk++; if (tdata !== 16'h0300) begin n_err++; $display("FAIL stall_pre got=%h exp=0300", tdata); end
        tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_chk++; if (tvalid !== 1'b1 || tdata !== 16'h0300) begin
                n_err++; $display("FAIL stall_hold%0d got=%b/%h exp=1/0300", k, tvalid, tdata); end
        end
        tready = 1'b1;
        tick();
        n_chk++; if (tdata !== 16'h0400) begin n_err++; $display("FAIL stall_resume got=%h exp=0400", tdata); end
        tick();
        n_chk++; if (tdata !== 16'h0500) begin n_err++; $display("FAIL stall_next got=%h exp=0500", tdata); end
        // enable drops while the beat is stalled: it must stay until taken
        tready = 1'b0;
        enable = 1'b0;
        tick();
        n_chk++; if (tvalid !== 1'b1 || tdata !== 16'h0500 || busy !== 1'b1) begin
            n_err++; $display("FAIL stall_final_hold got=%b/%h/%b exp=1/0500/1", tvalid, tdata, busy); end
        tready = 1'b1;
        tick();
        n_chk++; if (tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL stall_final_drop got=%b/%b exp=0/0", tvalid, busy); end
    endtask

    task automatic test_sweep_once();
        logic [15:0] exp_seq [4] = '{16'h0100, 16'h0300, 16'h0600, 16'h0A00};
        do_cfg(2'b01, 32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'h0000);
        enable = 1'b1;
        tick();
        n_chk++; if (tdata !== 16'h0000) begin n_err++; $display("FAIL once_first got=%h exp=0000", tdata); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (tvalid !== 1'b1 || tdata !== exp_seq[k] || sweep_done !== 1'b0) begin
                n_err++; $display("FAIL once_beat%0d got=%b/%h/%b exp=1/%h/0", k, tvalid, tdata, sweep_done, exp_seq[k]); end
        end
        tick();
        n_chk++; if (sweep_done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL once_done got=%b/%b/%b exp=1/0/0", sweep_done, tvalid, busy); end
        enable = 1'b0;
        tick();
        n_chk++; if (sweep_done !== 1'b0 || tvalid !== 1'b0) begin
            n_err++; $display("FAIL once_pulse got=%b/%b exp=0/0", sweep_done, tvalid); end
    endtask

    task automatic test_sweep_repeat();
        logic [15:0] exp_seq [10] = '{16'h0100, 16'h0300, 16'h0600, 16'h0A00, 16'h0B00,
                                      16'h0D00, 16'h1000, 16'h1400, 16'h1500, 16'h1700};
        do_cfg(2'b10, 32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'h0000);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            n_chk++; if (tvalid !== 1'b1 || tdata !== exp_seq[k] || sweep_done !== 1'b0) begin
                n_err++; $display("FAIL rep_beat%0d got=%b/%h/%b exp=1/%h/0", k, tvalid, tdata, sweep_done, exp_seq[k]); end
        end
        enable = 1'b0;
        tick();
        n_chk++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL rep_stop got=%b exp=0", tvalid); end
    endtask

    task automatic test_retune();
        do_cfg(2'b00, 32'h0100_0000, 32'h0, 32'h0, 16'h0000);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        n_chk++; if (tdata !== 16'h0500) begin n_err++; $display("FAIL retune_pre got=%h exp=0500", tdata); end
        cfg_mode = 2'b00; cfg_ftw = 32'h0200_0000; cfg_poff = 16'h0000; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_chk++; if (tdata !== 16'h0600) begin n_err++; $display("FAIL retune_old got=%h exp=0600", tdata); end
        tick();
        n_chk++; if (tdata !== 16'h0800) begin n_err++; $display("FAIL retune_new1 got=%h exp=0800", tdata); end
        tick();
        n_chk++; if (tdata !== 16'h0A00) begin n_err++; $display("FAIL retune_new2 got=%h exp=0a00", tdata); end
        // asynchronous reset mid-stream, checked before the next clock edge
        reset = 1'b1;
        #1;
        n_chk++; if (tvalid !== 1'b0 || tdata !== 16'h0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_mid got=%b/%h/%b exp=0/0000/0", tvalid, tdata, busy); end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_poff();
        test_stall();
        test_sweep_once();
        test_sweep_repeat();
        test_retune();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
